spi_main_param: RTL and testbench

Parametrised SPI master; the next generation of the fixed 128-bit mode-0 SPI_Main.
- Generic word width and clock divider.
- Run-time CPOL/CPHA selection; MSB- or LSB-first shifting.
- Multiple chip selects.
- Full-duplex: shifts tx out on mosi while capturing miso into rx.
- Sits between the AES datapath and the SPI bus.

---
 rtl/spi_main_param_pkg.sv | 22 ++
 rtl/spi_main_param_if.sv | 31 +++
 rtl/spi_main_param_clk_strobe.sv | 26 ++
 rtl/spi_main_param.sv | 134 +++++++++++++
 tb/tb_spi_main_param.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_main_param_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } spi_state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_sel_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_main_param_if.sv
// Host request/response and SPI bus signals of one SPI master.
interface spi_main_param_if #(
    parameter int DATA_W = 128,
    parameter int NUM_CS = 1
);
    localparam int CS_W = spi_pkg::cs_sel_w(NUM_CS);

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [CS_W-1:0]   cs_sel;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [NUM_CS-1:0] cs_n;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              busy;
    logic              done;

    modport master (
        input  start, cpol, cpha, cs_sel, tx, miso,
        output rx, cs_n, sclk, mosi, busy, done
    );

    modport slave (
        output start, cpol, cpha, cs_sel, tx, miso,
        input  rx, cs_n, sclk, mosi, busy, done
    );

endinterface

// File: rtl/spi_main_param_clk_strobe.sv
// Divider for the SPI half-period: one-cycle strobe every CLK_DIV clocks.
module spi_clk_strobe #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_strobe
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_div_cnt;

    assign o_strobe = (r_div_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_clr || o_strobe) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_main_param.sv
// Parametrised full-duplex SPI master: run-time CPOL/CPHA, MSB/LSB-first,
// several chip selects; tx and rx share one shift register.
module spi_main_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int CLK_DIV   = 2,
    parameter int NUM_CS    = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    spi_main_param_if.master bus
);
    localparam int CS_W   = cs_sel_w(NUM_CS);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_t        r_state;
    spi_state_t        w_next;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_sclk;
    logic              r_mosi;
    logic [CS_W-1:0]   r_cs_sel;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_rx;

    logic              w_strobe;
    logic              w_div_clr;
    logic              w_accept;
    logic              w_lead;
    logic              w_last;
    logic              w_out_bit;
    logic              w_first_tx;
    logic [DATA_W-1:0] w_shifted;

    assign w_accept   = (r_state == IDLE) && bus.start && (int'(bus.cs_sel) < NUM_CS);
    // edge_cnt counts completed edges, so the upcoming edge is leading when it is even
    assign w_lead     = ~r_edge_cnt[0];
    assign w_last     = (r_edge_cnt == LAST_EDGE);
    assign w_out_bit  = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[DATA_W-1];
    assign w_first_tx = (LSB_FIRST != 0) ? bus.tx[0] : bus.tx[DATA_W-1];
    assign w_shifted  = (LSB_FIRST != 0) ? {bus.miso, r_shreg[DATA_W-1:1]}
                                         : {r_shreg[DATA_W-2:0], bus.miso};
    assign w_div_clr  = (r_state == IDLE) || (w_next != r_state);

    spi_clk_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_div_clr),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LEAD;
            LEAD:    if (w_strobe) w_next = XFER;
            XFER:    if (w_strobe && w_last) w_next = TRAIL;
            TRAIL:   if (w_strobe) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cs_n = '1;
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
        if (r_state inside {LEAD, XFER, TRAIL}) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (r_cs_sel == CS_W'(i)) bus.cs_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs_sel   <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_edge_cnt <= '0;
            r_rx       <= '0;
        end else begin
            if (w_accept) begin
                r_cpol     <= bus.cpol;
                r_cpha     <= bus.cpha;
                r_cs_sel   <= bus.cs_sel;
                r_sclk     <= bus.cpol;
                r_edge_cnt <= '0;
                r_mosi     <= bus.cpha ? 1'b0 : w_first_tx;
            end
            if (r_state == XFER && w_strobe) begin
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                // cpha=1 launches on leading edges; cpha=0 on trailing, none after the last
                if (r_cpha ? w_lead : (!w_lead && !w_last)) r_mosi <= w_out_bit;
            end
            if (r_state == TRAIL && w_strobe) begin
                r_rx   <= r_shreg;
                r_mosi <= 1'b0;
                r_sclk <= r_cpol;
            end
        end
    end

    // Shift register: data only, loaded at accept so it needs no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shreg <= bus.tx;
        end else if (r_state == XFER && w_strobe && (w_lead ^ r_cpha)) begin
            r_shreg <= w_shifted;
        end
    end

    assign bus.rx   = r_rx;
    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;

endmodule

// File: tb/tb_spi_main_param.sv
// Directed bench for spi_main_param: three configurations, loopback and a mode-3 slave model.
module tb_spi_main_param;
    import spi_pkg::*;

    localparam logic [127:0] TX1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] TX2 = 128'h99999999999999999;
    localparam logic [127:0] SUB = 128'h555555555555555555;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop0 = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    spi_main_param_if #(.DATA_W(128), .NUM_CS(1)) bus0 ();
    spi_main_param_if #(.DATA_W(8),   .NUM_CS(1)) bus1 ();
    spi_main_param_if #(.DATA_W(16),  .NUM_CS(4)) bus2 ();

    spi_main_param #(.DATA_W(128), .CLK_DIV(2), .NUM_CS(1), .LSB_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0.master));
    spi_main_param #(.DATA_W(8),   .CLK_DIV(2), .NUM_CS(1), .LSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.master));
    spi_main_param #(.DATA_W(16),  .CLK_DIV(2), .NUM_CS(4), .LSB_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .bus(bus2.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode-3 slave on u0: drives on falling sclk, captures on rising sclk
    logic [127:0] s_tx = SUB;
    logic [127:0] s_rx = '0;
    logic         s_miso = 1'b0;

    always @(negedge bus0.sclk or posedge bus0.cs_n[0]) begin
        if (bus0.cs_n[0]) begin
            s_tx <= SUB;
        end else begin
            s_miso <= s_tx[127];
            s_tx   <= s_tx << 1;
        end
    end

    always @(posedge bus0.sclk) begin
        if (!bus0.cs_n[0]) s_rx <= {s_rx[126:0], bus0.mosi};
    end

    assign bus0.miso = loop0 ? bus0.mosi : s_miso;
    assign bus1.miso = bus1.mosi;
    assign bus2.miso = bus2.mosi;

    int dn0 = 0, dn1 = 0, dn2 = 0;
    int dc0 = 0, dc1 = 0, dc2 = 0;
    int lo_cnt0 = 0, lo_first0 = 0, lo_last0 = 0;
    logic       prev1 = 1'b0;
    logic [7:0] rec1 = '0;

    always @(negedge clk) begin
        if (bus0.done) begin dn0 <= dn0 + 1; dc0 <= cyc; end
        if (bus1.done) begin dn1 <= dn1 + 1; dc1 <= cyc; end
        if (bus2.done) begin dn2 <= dn2 + 1; dc2 <= cyc; end
        if (!bus0.cs_n[0]) begin
            lo_cnt0  <= lo_cnt0 + 1;
            lo_last0 <= cyc;
            if (lo_cnt0 == 0) lo_first0 <= cyc;
        end
        if (!prev1 && bus1.sclk) rec1 <= {rec1[6:0], bus1.mosi};
        prev1 <= bus1.sclk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    function automatic int dn_of(input int w);
        case (w)
            0:       return dn0;
            1:       return dn1;
            default: return dn2;
        endcase
    endfunction

    task automatic wait_dn(input int w, input int base, input int limit);
        int k = 0;
        while (dn_of(w) == base && k < limit) begin
            tick();
            k++;
        end
        chk("done_seen", 128'(dn_of(w) != base), 128'd1);
    endtask

    task automatic xfer0(input logic [127:0] tx, input logic [1:0] mode, output int lat);
        int b, t0;
        bus0.tx = tx;
        {bus0.cpol, bus0.cpha} = mode;
        bus0.cs_sel = '0;
        bus0.start = 1'b1;
        t0 = cyc;
        b = dn0;
        tick();
        bus0.start = 1'b0;
        wait_dn(0, b, 700);
        lat = dc0 - t0;
    endtask

    task automatic xfer2(input logic [15:0] tx, input logic [1:0] mode, input logic [1:0] cs,
                         output int lat);
        int b, t0;
        bus2.tx = tx;
        {bus2.cpol, bus2.cpha} = mode;
        bus2.cs_sel = cs;
        bus2.start = 1'b1;
        t0 = cyc;
        b = dn2;
        tick();
        bus2.start = 1'b0;
        wait_dn(2, b, 200);
        lat = dc2 - t0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, b;
        {bus0.start, bus0.cpol, bus0.cpha, bus0.cs_sel, bus0.tx} = '0;
        {bus1.start, bus1.cpol, bus1.cpha, bus1.cs_sel, bus1.tx} = '0;
        {bus2.start, bus2.cpol, bus2.cpha, bus2.cs_sel, bus2.tx} = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_cs_n0", bus0.cs_n, 1'b1);
        chk("rst_cs_n2", bus2.cs_n, 4'hF);
        chk("rst_sclk",  bus0.sclk, 1'b0);
        chk("rst_mosi",  bus0.mosi, 1'b0);
        chk("rst_busy",  bus0.busy, 1'b0);
        chk("rst_done",  bus0.done, 1'b0);
        chk("rst_rx",    bus0.rx, 128'd0);
        rst = 1'b0;
        tick();

        // Mode 0 loopback, 128 bits, MSB first
        xfer0(TX1, MODE0, lat);
        chk("t1_latency", lat, 517);
        chk("t1_rx", bus0.rx, TX1);
        chk("t1_busy_in_done", bus0.busy, 1'b1);
        chk("t1_cs_first", lo_first0 - (dc0 - 517), 1);
        chk("t1_cs_last", lo_last0 - (dc0 - 517), 516);
        chk("t1_cs_cnt", lo_cnt0, 516);
        tick();
        chk("t1_busy_after", bus0.busy, 1'b0);
        chk("t1_single_done", dn0, 1);

        // Mode 3 against the slave model, twice so the second starts from an idle-high sclk
        loop0 = 1'b0;
        xfer0(TX2, MODE3, lat);
        chk("t2a_rx", bus0.rx, SUB);
        chk("t2a_sub_rx", s_rx, TX2);
        tick();
        chk("t2_idle_hi", bus0.sclk, 1'b1);
        xfer0(TX2, MODE3, lat);
        chk("t2b_latency", lat, 517);
        chk("t2b_rx", bus0.rx, SUB);
        chk("t2b_sub_rx", s_rx, TX2);
        tick();
        chk("t2b_idle_hi", bus0.sclk, 1'b1);

        // 8-bit LSB-first mode 1 loopback
        bus1.tx = 8'hA1;
        {bus1.cpol, bus1.cpha} = MODE1;
        bus1.cs_sel = '0;
        bus1.start = 1'b1;
        t0 = cyc;
        b = dn1;
        tick();
        bus1.start = 1'b0;
        wait_dn(1, b, 100);
        chk("t3_latency", dc1 - t0, 37);
        chk("t3_rx", bus1.rx, 8'hA1);
        chk("t3_mosi_seq", rec1, 8'h85);

        // Out-of-range select is ignored (NUM_CS=1, cs_sel=1)
        tick();
        b = dn1;
        bus1.cs_sel = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("t4_bad_cs_busy", bus1.busy, 1'b0);
        chk("t4_bad_cs_csn", bus1.cs_n, 1'b1);
        repeat (40) tick();
        chk("t4_bad_cs_nodone", dn1 - b, 0);

        // cs_sel=2 on four selects, plus start pulses mid-XFER and in DONE
        bus2.tx = 16'hFA4D;
        {bus2.cpol, bus2.cpha} = MODE0;
        bus2.cs_sel = 2'd2;
        bus2.start = 1'b1;
        t0 = cyc;
        b = dn2;
        tick();
        bus2.start = 1'b0;
        chk("t4_cs_n", bus2.cs_n, 4'b1011);
        chk("t4_busy", bus2.busy, 1'b1);
        wait_until(t0 + 20);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        wait_until(t0 + 69);
        chk("t5_done_at_69", bus2.done, 1'b1);
        chk("t4_rx", bus2.rx, 16'hFA4D);
        bus2.start = 1'b1;
        bus2.tx = 16'h1234;
        tick();
        chk("t5_idle_after_done", bus2.busy, 1'b0);
        chk("t5_done_pulse", bus2.done, 1'b0);
        tick();
        bus2.start = 1'b0;
        chk("t5_b2b_accept", bus2.busy, 1'b1);
        wait_dn(2, b + 1, 200);
        chk("t5_b2b_latency", dc2 - t0, 139);
        chk("t5_b2b_rx", bus2.rx, 16'h1234);
        chk("t5_done_count", dn2 - b, 2);
        tick();

        // Reset in the middle of a mode-2 transfer
        bus2.tx = 16'h5AC3;
        {bus2.cpol, bus2.cpha} = MODE2;
        bus2.cs_sel = 2'd1;
        bus2.start = 1'b1;
        t0 = cyc;
        tick();
        bus2.start = 1'b0;
        wait_until(t0 + 31);
        chk("t6_sclk_pre", bus2.sclk, 1'b1);
        chk("t6_busy_pre", bus2.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_cs_n", bus2.cs_n, 4'hF);
        chk("t6_sclk", bus2.sclk, 1'b0);
        chk("t6_busy", bus2.busy, 1'b0);
        chk("t6_rx", bus2.rx, 16'h0000);
        chk("t6_mosi", bus2.mosi, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        xfer2(16'hC3A5, MODE0, 2'd3, lat);
        chk("t6_new_latency", lat, 69);
        chk("t6_new_rx", bus2.rx, 16'hC3A5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
